// File: rtl/csa_acc_ctrl.sv
// csa_acc_ctrl: job-based accumulator fed by a 4-operand carry-save adder.
// A job of 'len' groups is loaded one beat at a time. Each beat is reduced
// by the CSA and then added into a wide accumulator. The result is held
// until the consumer accepts it.

// Four-operand carry-save adder: two 3:2 compression levels followed by a
// single carry-propagate add. The result is exactly a+b+c+d.
module csa4 #(
    parameter int BW = 4
) (
    input  logic [BW-1:0] a_i,
    input  logic [BW-1:0] b_i,
    input  logic [BW-1:0] c_i,
    input  logic [BW-1:0] d_i,
    output logic [BW+1:0] sum_o
);
    logic [BW-1:0] s1;
    logic [BW-1:0] k1;
    logic [BW:0]   x2;
    logic [BW:0]   y2;
    logic [BW:0]   z2;
    logic [BW:0]   s2;
    logic [BW:0]   k2;

    // First level: compress a, b, c into a sum and a carry vector.
    for (genvar gi = 0; gi < BW; gi++) begin : g_lvl1
        assign s1[gi] = a_i[gi] ^ b_i[gi] ^ c_i[gi];
        assign k1[gi] = (a_i[gi] & b_i[gi]) | (a_i[gi] & c_i[gi]) | (b_i[gi] & c_i[gi]);
    end

    // Align the level-one outputs and d on a BW+1 bit grid.
    // The carries carry weight 2, so they move up one bit.
    assign x2 = {1'b0, s1};
    assign y2 = {k1, 1'b0};
    assign z2 = {1'b0, d_i};

    // Second level: fold d in with the level-one sum and carry.
    for (genvar gi = 0; gi <= BW; gi++) begin : g_lvl2
        assign s2[gi] = x2[gi] ^ y2[gi] ^ z2[gi];
        assign k2[gi] = (x2[gi] & y2[gi]) | (x2[gi] & z2[gi]) | (y2[gi] & z2[gi]);
    end

    // The final carry-propagate add. Since 4*(2^BW-1) < 2^(BW+2), nothing is lost.
    assign sum_o = {1'b0, s2} + {k2, 1'b0};
endmodule

module csa_acc_ctrl #(
    parameter int BW    = 4,
    parameter int ACC_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        len,
    input  logic [4*BW-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overflow
);
    localparam int AW1 = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [4*BW-1:0]    opnd_q, opnd_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;

    logic [BW-1:0]      d_op [4];
    logic [BW+1:0]      csa_sum;
    logic [ACC_W:0]     acc_wide;

    // Split the operand register into D0..D3, with D0 in the LSBs.
    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign d_op[gi] = opnd_q[gi*BW +: BW];
    end

    csa4 #(.BW(BW)) u_csa (
        .a_i   (d_op[0]),
        .b_i   (d_op[1]),
        .c_i   (d_op[2]),
        .d_i   (d_op[3]),
        .sum_o (csa_sum)
    );

    // The add is one bit wider than the accumulator.
    // Its top bit is the carry out of the ACC_W-bit add.
    assign acc_wide = {1'b0, acc_q} + AW1'(csa_sum);

    // State and datapath registers. Reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == 8'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opnd_d  = in_data;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                acc_d   = acc_wide[ACC_W-1:0];
                ovf_d   = ovf_q | acc_wide[ACC_W];
                cnt_d   = cnt_q + 8'd1;
                state_d = (cnt_q + 8'd1 == len_q) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // acc only changes during ADD and at start. The last result therefore
    // stays visible after DONE until the next job clears it.
    assign acc_out  = acc_q;
    assign overflow = ovf_q;
endmodule
